// File: rtl/count_mon_pkg.sv
// Shared types for the count period monitor: record layout, FSM states and the
// saturating period increment.
package count_mon_pkg;
  localparam int CNT_W_DEF = 4;
  localparam int PER_W_DEF = 8;
  localparam int DEPTH_DEF = 4;

  typedef struct packed {
    logic [PER_W_DEF-1:0] period;
    logic                 err;
  } cnt_rec_t;

  typedef enum logic {IDLE = 1'b0, TRACK = 1'b1} cnt_mon_state_t;

  // Clamp at all-ones instead of wrapping back to zero.
  function automatic logic [PER_W_DEF-1:0] sat_inc(input logic [PER_W_DEF-1:0] x);
    return (&x) ? x : x + 1'b1;
  endfunction
endpackage

// File: rtl/count_rec_fifo.sv
// DEPTH-entry record FIFO; a push while full is accepted only when a pop
// happens on the same edge.
module count_rec_fifo
  import count_mon_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     i_push,
  input  logic     i_pop,
  input  cnt_rec_t i_wdata,
  output cnt_rec_t o_rdata,
  output logic     o_full,
  output logic     o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr, r_rd;
  cnt_rec_t    r_mem [DEPTH];
  logic        w_pop, w_push;

  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_rdata = r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  // Storage needs no reset: reads are masked by o_empty downstream.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= i_wdata;
  end
endmodule

// File: rtl/count_period_monitor.sv
// Checks a counter sample stream for strict +1 steps, measures wrap period in
// samples and queues {period, err} records for a valid/ready consumer.
module count_period_monitor
  import count_mon_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int PER_W = PER_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [CNT_W-1:0] in_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PER_W-1:0] out_period,
  output logic             out_err,
  output logic             overflow
);
  cnt_mon_state_t   r_state;
  logic [CNT_W-1:0] r_prev;
  logic [PER_W-1:0] r_period;
  logic             r_overflow;

  logic [CNT_W-1:0] w_exp;
  logic             w_match, w_close, w_pop, w_full, w_empty;
  cnt_rec_t         w_rec, w_head;

  assign w_exp   = r_prev + 1'b1;
  assign w_match = (in_count == w_exp);
  // A record closes on a clean wrap (expected value is zero) or on any break.
  assign w_close = (r_state == TRACK) && in_valid && (!w_match || (w_exp == '0));
  assign w_rec   = '{period: sat_inc(r_period), err: !w_match};
  assign w_pop   = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_prev   <= '0;
      r_period <= '0;
    end else if (in_valid) begin
      r_prev <= in_count;
      case (r_state)
        IDLE: begin
          r_period <= '0;
          r_state  <= TRACK;
        end
        TRACK: r_period <= w_close ? '0 : sat_inc(r_period);
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          r_overflow <= 1'b0;
    else if (w_close && w_full && !w_pop) r_overflow <= 1'b1;
  end

  count_rec_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_close),
    .i_pop   (w_pop),
    .i_wdata (w_rec),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign out_valid  = !w_empty;
  assign out_period = out_valid ? w_head.period : '0;
  assign out_err    = out_valid ? w_head.err    : 1'b0;
  assign overflow   = r_overflow;
endmodule

// File: tb/tb_count_period_monitor.sv
// Directed bench for count_period_monitor: wraps, sequence breaks, sparse
// valid, FIFO full/overflow, simultaneous push+pop and mid-stream reset.
module tb_count_period_monitor;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_count = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_period;
  logic       out_err;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  count_period_monitor #(.CNT_W(4), .PER_W(8), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_count   (in_count),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_period (out_period),
    .out_err    (out_err),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive at the falling edge, return 1ns after the following rising edge.
  task automatic step(input logic v, input logic [3:0] c, input logic rdy);
    @(negedge clk);
    in_valid  = v;
    in_count  = c;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_out_period", 32'(out_period), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Samples 1..15 then 0: one clean wrap of period 16 (reference already held).
  task automatic wrap(input logic rdy_last);
    for (int k = 1; k < 16; k++) step(1'b1, 4'(k), 1'b0);
    step(1'b1, 4'd0, rdy_last);
  endtask

  initial begin
    // 1: reset asserted mid-cycle
    do_reset();

    // 2: one full clean wrap
    step(1'b1, 4'd0, 1'b1);
    for (int k = 1; k < 16; k++) step(1'b1, 4'(k), 1'b1);
    chk("t2_before_close", 32'(out_valid), 0);
    step(1'b1, 4'd0, 1'b1);
    chk("t2_valid", 32'(out_valid), 1);
    chk("t2_period", 32'(out_period), 16);
    chk("t2_err", 32'(out_err), 0);
    step(1'b0, 4'd0, 1'b1);
    chk("t2_one_cycle", 32'(out_valid), 0);
    chk("t2_period_zero", 32'(out_period), 0);

    // 3: sequence break then resync
    do_reset();
    step(1'b1, 4'd0, 1'b1);
    step(1'b1, 4'd1, 1'b1);
    step(1'b1, 4'd2, 1'b1);
    step(1'b1, 4'd4, 1'b1);
    chk("t3_err_valid", 32'(out_valid), 1);
    chk("t3_err_period", 32'(out_period), 3);
    chk("t3_err_flag", 32'(out_err), 1);
    for (int k = 5; k < 16; k++) step(1'b1, 4'(k), 1'b1);
    chk("t3_drained", 32'(out_valid), 0);
    step(1'b1, 4'd0, 1'b1);
    chk("t3_wrap_valid", 32'(out_valid), 1);
    chk("t3_wrap_period", 32'(out_period), 12);
    chk("t3_wrap_err", 32'(out_err), 0);

    // 4: in_valid toggling does not count idle cycles
    do_reset();
    step(1'b1, 4'd0, 1'b0);
    step(1'b0, 4'd9, 1'b0);
    for (int k = 1; k < 16; k++) begin
      step(1'b1, 4'(k), 1'b0);
      step(1'b0, 4'd3, 1'b0);
    end
    chk("t4_before_close", 32'(out_valid), 0);
    step(1'b1, 4'd0, 1'b0);
    chk("t4_valid", 32'(out_valid), 1);
    chk("t4_period", 32'(out_period), 16);
    chk("t4_err", 32'(out_err), 0);

    // 5: FIFO fills, fifth record dropped, then drain
    do_reset();
    step(1'b1, 4'd0, 1'b0);
    for (int w = 0; w < 4; w++) wrap(1'b0);
    chk("t5_full_no_ovf", 32'(overflow), 0);
    wrap(1'b0);
    chk("t5_overflow", 32'(overflow), 1);
    chk("t5_valid", 32'(out_valid), 1);
    for (int d = 0; d < 4; d++) begin
      chk("t5_drain_valid", 32'(out_valid), 1);
      chk("t5_drain_period", 32'(out_period), 16);
      step(1'b0, 4'd0, 1'b1);
    end
    chk("t5_empty", 32'(out_valid), 0);
    chk("t5_ovf_sticky", 32'(overflow), 1);

    // 6: full FIFO, pop in the push cycle keeps every record
    do_reset();
    step(1'b1, 4'd0, 1'b0);
    for (int w = 0; w < 4; w++) wrap(1'b0);
    wrap(1'b1);
    chk("t6_no_ovf", 32'(overflow), 0);
    for (int d = 0; d < 4; d++) begin
      chk("t6_drain_valid", 32'(out_valid), 1);
      chk("t6_drain_period", 32'(out_period), 16);
      step(1'b0, 4'd0, 1'b1);
    end
    chk("t6_empty", 32'(out_valid), 0);

    // 7: reset while records queued and tracking
    do_reset();
    step(1'b1, 4'd0, 1'b0);
    wrap(1'b0);
    wrap(1'b0);
    step(1'b1, 4'd1, 1'b0);
    step(1'b1, 4'd2, 1'b0);
    chk("t7_queued", 32'(out_valid), 1);
    do_reset();
    step(1'b1, 4'd7, 1'b0);
    chk("t7_ref_only", 32'(out_valid), 0);
    step(1'b1, 4'd8, 1'b0);
    chk("t7_clean_step", 32'(out_valid), 0);
    step(1'b1, 4'd10, 1'b0);
    chk("t7_err_valid", 32'(out_valid), 1);
    chk("t7_err_period", 32'(out_period), 2);
    chk("t7_err_flag", 32'(out_err), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
